// File: rtl/noc_accum_sink_pkg.sv
// noc_accum_sink_pkg: NoC word layout, accumulator sizing and sink FSM encodings shared with the tree arbiters
package noc_accum_sink_pkg;
  localparam int BIT_WIDTH = 16;
  localparam int LOG_N_ADD = 6;
  localparam int CTRL_BIT = 1;
  localparam int ACC_WIDTH = BIT_WIDTH + 8;
  localparam int N_ADD = 2 ** LOG_N_ADD;
  localparam int DATA_LSB = 0;
  localparam int ADDR_LSB = DATA_LSB + BIT_WIDTH;
  localparam int VAL_BIT = ADDR_LSB + LOG_N_ADD;
  localparam int WORD_W = VAL_BIT + CTRL_BIT;
  typedef logic [WORD_W-1:0] noc_word_t;
  typedef logic [LOG_N_ADD-1:0] addr_t;
  typedef logic [ACC_WIDTH-1:0] acc_t;
  typedef struct packed {
    logic v;
    addr_t addr;
    acc_t data;
  } s1_t;
  localparam logic [1:0] ACCUM = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  function automatic acc_t sext(input logic [BIT_WIDTH-1:0] d);
    return {{(ACC_WIDTH - BIT_WIDTH){d[BIT_WIDTH-1]}}, d};
  endfunction
endpackage

// File: rtl/noc_accum_sink_if.sv
// noc_accum_sink_if: tree-root word, busy back-pressure, drain request and drain stream
interface noc_accum_sink_if;
  import noc_accum_sink_pkg::*;
  noc_word_t word;
  logic busy;
  logic drain_req;
  acc_t out_data;
  addr_t out_addr;
  logic out_ovf;
  logic out_valid;
  logic out_ready;
  logic drain_done;
  modport master(output word, drain_req, out_ready,
                 input busy, out_data, out_addr, out_ovf, out_valid, drain_done);
  modport slave(input word, drain_req, out_ready,
                output busy, out_data, out_addr, out_ovf, out_valid, drain_done);
endinterface

// File: rtl/noc_accum_sink_acc_bank.sv
// noc_accum_sink_acc_bank: accumulator register array with sticky signed-overflow flags
module noc_accum_sink_acc_bank
  import noc_accum_sink_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic we_i,
  input  addr_t waddr_i,
  input  acc_t wdata_i,
  input  logic clr_i,
  input  addr_t raddr_i,
  output acc_t rdata_o,
  output logic rovf_o
);
  acc_t acc_q [N_ADD];
  logic [N_ADD-1:0] ovf_q;
  acc_t sum;
  logic ov;
  assign sum = acc_q[waddr_i] + wdata_i;
  // overflow: operands agree in sign but the result does not
  assign ov = (acc_q[waddr_i][ACC_WIDTH-1] == wdata_i[ACC_WIDTH-1]) &&
              (sum[ACC_WIDTH-1] != wdata_i[ACC_WIDTH-1]);
  assign rdata_o = acc_q[raddr_i];
  assign rovf_o = ovf_q[raddr_i];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ADD; i++) acc_q[i] <= '0;
      ovf_q <= '0;
    end else begin
      if (we_i) begin
        acc_q[waddr_i] <= sum;
        ovf_q[waddr_i] <= ovf_q[waddr_i] | ov;
      end
      if (clr_i) begin
        acc_q[raddr_i] <= '0;
        ovf_q[raddr_i] <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/noc_accum_sink.sv
// noc_accum_sink: accumulates merged NoC words per address and streams/clears the bank on drain
module noc_accum_sink
  import noc_accum_sink_pkg::*;
(
  input logic clk,
  input logic rst,
  noc_accum_sink_if.slave bus_io
);
  logic [1:0] state_q, state_d;
  addr_t idx_q, idx_d;
  logic busy_q;
  s1_t s1_q, s1_d;
  logic fire;
  assign fire = (state_q == DRAIN) && bus_io.out_ready;
  always_comb begin
    s1_d = '{v: bus_io.word[VAL_BIT] & ~busy_q,
             addr: bus_io.word[ADDR_LSB +: LOG_N_ADD],
             data: sext(bus_io.word[DATA_LSB +: BIT_WIDTH])};
    idx_d = fire ? idx_q + 1'b1 : idx_q;
    state_d = (state_q == ACCUM) ? (bus_io.drain_req ? FLUSH : ACCUM) :
              (state_q == FLUSH) ? DRAIN :
              (state_q == DRAIN) ? ((fire && idx_q == '1) ? DONE : DRAIN) : ACCUM;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      idx_q <= '0;
      busy_q <= 1'b0;
      s1_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      busy_q <= state_d != ACCUM;
      s1_q <= s1_d;
    end
  end
  noc_accum_sink_acc_bank u_bank (
    .clk(clk),
    .rst(rst),
    .we_i(s1_q.v),
    .waddr_i(s1_q.addr),
    .wdata_i(s1_q.data),
    .clr_i(fire),
    .raddr_i(idx_q),
    .rdata_o(bus_io.out_data),
    .rovf_o(bus_io.out_ovf)
  );
  assign bus_io.busy = busy_q;
  assign bus_io.out_valid = state_q == DRAIN;
  assign bus_io.out_addr = idx_q;
  assign bus_io.drain_done = state_q == DONE;
endmodule

// File: tb/tb_noc_accum_sink.sv
// tb_noc_accum_sink: directed checks of accumulate, overflow, drain handshake and reset for noc_accum_sink
module tb_noc_accum_sink;
  import noc_accum_sink_pkg::*;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  noc_accum_sink_if bus();
  noc_accum_sink dut (.clk(clk), .rst(rst), .bus_io(bus));
  int errors = 0;
  int checks = 0;
  acc_t d_data [N_ADD];
  logic d_ovf [N_ADD];
  int n_acc, busy_drop, order_bad;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int a, input int d);
    bus.word = {1'b1, 6'(a), 16'(d)};
    step();
    bus.word = '0;
  endtask
  task automatic start_drain;
    bus.drain_req = 1'b1;
    step();
    bus.drain_req = 1'b0;
  endtask
  task automatic collect(input bit bp, input int lim);
    int cyc = 0;
    n_acc = 0;
    busy_drop = 0;
    order_bad = 0;
    for (int i = 0; i < N_ADD; i++) begin
      d_data[i] = '0;
      d_ovf[i] = 1'b0;
    end
    while (n_acc < lim && cyc < 2000) begin
      bus.out_ready = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      if (!bus.busy) busy_drop++;
      if (bus.out_valid && bus.out_ready) begin
        if (bus.out_addr != 6'(n_acc)) order_bad++;
        d_data[bus.out_addr] = bus.out_data;
        d_ovf[bus.out_addr] = bus.out_ovf;
        n_acc++;
      end
      step();
      cyc++;
    end
    bus.out_ready = 1'b0;
    check("drain_count", n_acc, lim);
    check("drain_order", order_bad, 0);
    check("busy_in_drain", busy_drop, 0);
  endtask
  task automatic finish_drain;
    check("done_pulse", bus.drain_done, 1);
    check("busy_in_done", bus.busy, 1);
    step();
    check("done_clear", bus.drain_done, 0);
    check("busy_release", bus.busy, 0);
  endtask
  task automatic full_drain;
    start_drain();
    check("busy_after_req", bus.busy, 1);
    collect(1'b0, N_ADD);
    finish_drain();
  endtask
  function automatic int nz_data(input int skip);
    int c = 0;
    for (int i = 0; i < N_ADD; i++) if (i != skip && d_data[i] != '0) c++;
    return c;
  endfunction
  function automatic int nz_ovf;
    int c = 0;
    for (int i = 0; i < N_ADD; i++) if (d_ovf[i]) c++;
    return c;
  endfunction
  initial begin
    bus.word = '0;
    bus.out_ready = 1'b0;
    bus.drain_req = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    bus.drain_req = 1'b0;
    step();
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_done", bus.drain_done, 0);
    check("rst_addr", bus.out_addr, 0);
    send(3, 5);
    send(3, -2);
    full_drain();
    check("t1_acc3", d_data[3], 24'h3);
    check("t1_others", nz_data(3), 0);
    repeat (256) send(0, 16'h7FFF);
    full_drain();
    check("t2_sum", d_data[0], 24'h7FFF00);
    check("t2_ovf0", d_ovf[0], 0);
    repeat (257) send(0, 16'h7FFF);
    full_drain();
    check("t2_wrap", d_data[0], 24'h807EFF);
    check("t2_ovf1", d_ovf[0], 1);
    full_drain();
    check("t2_cleared", d_data[0], 0);
    check("t2_ovf_cleared", nz_ovf(), 0);
    bus.word = {1'b1, 6'd7, 16'd9};
    bus.drain_req = 1'b1;
    step();
    bus.word = '0;
    bus.drain_req = 1'b0;
    check("t3_busy", bus.busy, 1);
    collect(1'b0, N_ADD);
    finish_drain();
    check("t3_acc7", d_data[7], 24'd9);
    send(40, 3);
    start_drain();
    collect(1'b1, N_ADD);
    finish_drain();
    check("t4_acc40", d_data[40], 24'd3);
    check("t4_others", nz_data(40), 0);
    start_drain();
    bus.word = {1'b1, 6'd5, 16'd11};
    collect(1'b0, N_ADD);
    check("t5_held_out", d_data[5], 0);
    finish_drain();
    step();
    bus.word = '0;
    full_drain();
    check("t5_acc5", d_data[5], 24'd11);
    check("t5_others", nz_data(5), 0);
    send(20, 4);
    send(2, 1);
    start_drain();
    collect(1'b0, 10);
    check("t6_idx", bus.out_addr, 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_valid", bus.out_valid, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_done", bus.drain_done, 0);
    check("t6_addr", bus.out_addr, 0);
    full_drain();
    check("t6_zero", nz_data(-1), 0);
    check("t6_ovf", nz_ovf(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
